// File: rtl/cache_set_ctrl.sv
// Request sequencer for a single K-way cache set: lookup, miss fetch, write-through fill and
// one response per request over valid/ready handshakes.
module cache_set_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned K          = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic                  set_enable,
  output logic                  set_read,
  output logic                  set_write,
  output logic [ADDR_WIDTH-1:0] set_addr,
  output logic [LINE_WIDTH-1:0] set_wdata,
  input  logic                  set_hit,
  input  logic [LINE_WIDTH-1:0] set_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data
);

  localparam int unsigned FillMax = 2 * K + 2;
  localparam int unsigned CntW    = $clog2(2 * K + 3);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StMemReq,
    StMemWait,
    StFill,
    StResp
  } state_e;

  state_e                  state_q, state_d;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   fill_q;
  logic [LINE_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_hit_q;
  logic                    rsp_err_q;
  logic [CntW-1:0]         cnt_q;
  logic                    fill_done;
  logic                    fill_timeout;

  // set_hit on the first fill cycle still reflects an earlier access, so it is ignored.
  assign fill_done    = (state_q == StFill) && (cnt_q != '0) && set_hit;
  // The counter reaches FillMax at the edge that leaves FILL.
  assign fill_timeout = (state_q == StFill) && !fill_done && (cnt_q == CntW'(FillMax - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_valid) state_d = req_write ? StMemReq : StLookup;
      StLookup:  state_d = StCheck;
      StCheck:   state_d = set_hit ? StResp : StMemReq;
      StMemReq:  if (mem_req_ready) state_d = wr_q ? StFill : StMemWait;
      StMemWait: if (mem_rsp_valid) state_d = StFill;
      StFill:    if (fill_done || fill_timeout) state_d = StResp;
      StResp:    if (rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_data;
      end
      if (state_q == StCheck && set_hit) begin
        rsp_data_q <= set_rdata;
        rsp_hit_q  <= 1'b1;
        rsp_err_q  <= 1'b0;
      end
      if (state_q == StMemReq && mem_req_ready && wr_q) fill_q <= wdata_q;
      if (state_q == StMemWait && mem_rsp_valid) fill_q <= mem_rsp_data;
      if (state_q == StFill) begin
        cnt_q <= cnt_q + CntW'(1);
        if (fill_done || fill_timeout) begin
          rsp_data_q <= fill_q;
          rsp_hit_q  <= 1'b0;
          rsp_err_q  <= fill_timeout;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    rsp_hit       = 1'b0;
    rsp_err       = 1'b0;
    set_enable    = 1'b0;
    set_read      = 1'b0;
    set_write     = 1'b0;
    set_addr      = '0;
    set_wdata     = '0;
    mem_req_valid = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (!reset) begin
      unique case (state_q)
        StIdle: req_ready = 1'b1;
        StLookup: begin
          set_enable = 1'b1;
          set_read   = 1'b1;
          set_addr   = addr_q;
        end
        StMemReq: begin
          mem_req_valid = 1'b1;
          mem_write     = wr_q;
          mem_addr      = addr_q;
          mem_wdata     = wdata_q;
        end
        StFill: begin
          set_addr  = addr_q;
          set_wdata = fill_q;
          // Strobes drop in the same cycle the set reports completion.
          set_enable = !fill_done;
          set_write  = !fill_done;
        end
        StResp: begin
          rsp_valid = 1'b1;
          rsp_data  = rsp_data_q;
          rsp_hit   = rsp_hit_q;
          rsp_err   = rsp_err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl with a CLOCK-replacement set model, a memory responder
// and a response scoreboard.
module tb_cache_set_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned LW = 32;
  localparam int unsigned K  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_data = '0;
  logic          req_ready, rsp_valid, rsp_hit, rsp_err;
  logic [LW-1:0] rsp_data;
  logic          set_enable, set_read, set_write;
  logic [AW-1:0] set_addr;
  logic [LW-1:0] set_wdata;
  logic          set_hit = 1'b0;
  logic [LW-1:0] set_rdata = '0;
  logic          mem_req_valid, mem_write;
  logic          mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rsp_data = '0;

  always #5 clock = ~clock;

  cache_set_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(K)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .set_enable(set_enable), .set_read(set_read), .set_write(set_write),
    .set_addr(set_addr), .set_wdata(set_wdata), .set_hit(set_hit), .set_rdata(set_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  logic any_out;
  assign any_out = |{req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err, set_enable, set_read,
                     set_write, set_addr, set_wdata, mem_req_valid, mem_write, mem_addr, mem_wdata};

  typedef struct {
    logic [LW-1:0] data;
    logic          hit;
    logic          err;
    bit            chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Set model: registered outputs, CLOCK victim choice, set_hit held while idle.
  bit [K-1:0]    s_vld = '0, s_ref = '0;
  int            s_hand = 0;
  logic [AW-1:0] s_tag [K];
  logic [LW-1:0] s_dat [K];
  bit            set_broken = 1'b0;

  always @(posedge clock) begin
    int w, h;
    bit found, done;
    bit [K-1:0] rb;
    found = 1'b0;
    w = 0;
    for (int i = 0; i < K; i++)
      if (s_vld[i] && s_tag[i] == set_addr) begin found = 1'b1; w = i; end
    if (set_enable && set_read) begin
      set_hit   <= found;
      set_rdata <= found ? s_dat[w] : '0;
      if (found) s_ref[w] <= 1'b1;
    end else if (set_enable && set_write) begin
      if (set_broken) begin
        set_hit <= 1'b0;
      end else begin
        rb = s_ref;
        h  = s_hand;
        if (!found) begin
          done = 1'b0;
          for (int i = 0; i < 2 * K + 1; i++)
            if (!done) begin
              if (s_vld[h] && rb[h]) begin rb[h] = 1'b0; h = (h + 1) % K; end
              else begin w = h; done = 1'b1; end
            end
          s_hand <= (w + 1) % K;
        end
        rb[w] = 1'b1;
        s_ref    <= rb;
        s_vld[w] <= 1'b1;
        s_tag[w] <= set_addr;
        s_dat[w] <= set_wdata;
        set_hit  <= 1'b1;
      end
    end
  end

  // Memory responder: drives on the falling edge from settled DUT outputs.
  logic [LW-1:0] mem [256];
  int            stall_left = 0, rsp_delay = 0, rsp_wait = 0, grant_cnt = 0;
  bit            rsp_pending = 1'b0;
  logic [AW-1:0] rsp_addr = '0, g_addr = '0;
  logic [LW-1:0] g_wdata = '0;
  logic          g_write = 1'b0;

  always @(negedge clock) begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (rsp_pending) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem[rsp_addr];
        rsp_pending   = 1'b0;
      end else begin
        rsp_wait--;
      end
    end else if (mem_req_valid) begin
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
        grant_cnt++;
        g_addr  = mem_addr;
        g_write = mem_write;
        g_wdata = mem_wdata;
        if (mem_write) begin
          mem[mem_addr] = mem_wdata;
        end else begin
          rsp_pending = 1'b1;
          rsp_wait    = rsp_delay;
          rsp_addr    = mem_addr;
        end
      end
    end
  end

  // Monitor and scoreboard pop.
  int            rsp_first_cyc = 0, wstrobe_cnt = 0, memv_cnt = 0, mem_unstable = 0;
  int            hold_bad = 0, rw_overlap = 0, rsp_seen = 0;
  logic          prev_rv = 1'b0, prev_rr = 1'b0, prev_mv = 1'b0, prev_rh = 1'b0, prev_re = 1'b0;
  logic          prev_mwr = 1'b0;
  logic [LW-1:0] prev_rd = '0, prev_mw = '0;
  logic [AW-1:0] prev_ma = '0;

  always @(negedge clock) begin
    if (set_write) wstrobe_cnt++;
    if (set_read && set_write) rw_overlap++;
    if (mem_req_valid) memv_cnt++;
    if (mem_req_valid && prev_mv &&
        ({mem_addr, mem_wdata, mem_write} != {prev_ma, prev_mw, prev_mwr})) mem_unstable++;
    if (prev_rv && !prev_rr &&
        (!rsp_valid || {rsp_data, rsp_hit, rsp_err} != {prev_rd, prev_rh, prev_re})) hold_bad++;
    if (rsp_valid) rsp_seen++;
    if (rsp_valid && !prev_rv) rsp_first_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_data) check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    prev_rv  = rsp_valid;
    prev_rr  = rsp_ready;
    prev_rd  = rsp_data;
    prev_rh  = rsp_hit;
    prev_re  = rsp_err;
    prev_mv  = mem_req_valid;
    prev_ma  = mem_addr;
    prev_mw  = mem_wdata;
    prev_mwr = mem_write;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                      input logic [LW-1:0] ed, input logic eh, input logic ee, input bit cd,
                      input int hold, output int lat);
    int n;
    exp_q.push_back('{ed, eh, ee, cd});
    if (hold > 0) rsp_ready = 1'b0;
    accept(wr, a, d);
    if (hold > 0) begin
      n = 0;
      while (!rsp_valid && n < 200) begin tick(); n++; end
      repeat (hold) tick();
      check("rsp_held_while_not_ready", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("rsp_arrived", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("req_ready_after_rsp", 64'(req_ready), 64'd1);
    lat = rsp_first_cyc - acc_cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, g0, w0, m0, s0, n;
    tick();
    tick();
    check("reset_outputs_zero", 64'(any_out), 64'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Cold read miss.
    mem[8'h10] = 32'hDEAD_BEEF;
    rsp_delay  = 0;
    g0 = grant_cnt;
    w0 = wstrobe_cnt;
    send(1'b0, 8'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 0, lat);
    check("miss_mem_grants", 64'(grant_cnt - g0), 64'd1);
    check("miss_mem_addr", 64'(g_addr), 64'h10);
    check("miss_mem_write", 64'(g_write), 64'd0);
    check("miss_fill_strobes", 64'(wstrobe_cnt - w0), 64'd1);
    check("miss_latency", 64'(lat), 64'd6);

    // Read hit on the same line.
    g0 = grant_cnt;
    send(1'b0, 8'h10, '0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 0, lat);
    check("hit_no_mem", 64'(grant_cnt - g0), 64'd0);
    check("hit_latency", 64'(lat), 64'd2);

    // Write-through with memory stalled four cycles.
    stall_left = 4;
    m0 = memv_cnt;
    send(1'b1, 8'h20, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 0, lat);
    check("wr_mem_valid_cycles", 64'(memv_cnt - m0), 64'd5);
    check("wr_mem_write", 64'(g_write), 64'd1);
    check("wr_mem_addr", 64'(g_addr), 64'h20);
    check("wr_mem_wdata", 64'(g_wdata), 64'h1234_5678);
    check("wr_latency", 64'(lat), 64'd7);

    // Allocated write reads back as a hit; response held for three cycles.
    send(1'b0, 8'h20, '0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 3, lat);

    // Fill two more lines, then a miss forces a CLOCK eviction.
    send(1'b1, 8'h30, 32'h3030_3030, 32'h3030_3030, 1'b0, 1'b0, 1'b1, 0, lat);
    send(1'b1, 8'h40, 32'h4040_4040, 32'h4040_4040, 1'b0, 1'b0, 1'b1, 0, lat);
    mem[8'h50] = 32'h5050_A5A5;
    w0 = wstrobe_cnt;
    send(1'b0, 8'h50, '0, 32'h5050_A5A5, 1'b0, 1'b0, 1'b1, 0, lat);
    check("evict_fill_strobes", 64'(wstrobe_cnt - w0), 64'd1);
    check("evict_latency", 64'(lat), 64'd6);
    send(1'b0, 8'h50, '0, 32'h5050_A5A5, 1'b1, 1'b0, 1'b1, 0, lat);
    check("evict_rehit_latency", 64'(lat), 64'd2);

    // Set never acknowledges the fill.
    set_broken = 1'b1;
    mem[8'h60] = 32'h6060_6060;
    w0 = wstrobe_cnt;
    send(1'b0, 8'h60, '0, '0, 1'b0, 1'b1, 1'b0, 0, lat);
    check("timeout_fill_cycles", 64'(wstrobe_cnt - w0), 64'(2 * K + 2));
    check("timeout_latency", 64'(lat), 64'd10);
    set_broken = 1'b0;

    // Reset while waiting for memory; the late return must be dropped.
    mem[8'h70] = 32'h7070_7070;
    rsp_delay  = 3;
    g0 = grant_cnt;
    accept(1'b0, 8'h70, '0);
    n = 0;
    while (grant_cnt == g0 && n < 50) begin tick(); n++; end
    check("midreset_mem_granted", 64'(grant_cnt - g0), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_outputs_zero", 64'(any_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("midreset_ready", 64'(req_ready), 64'd1);
    check("midreset_mem_withdrawn", 64'(mem_req_valid), 64'd0);
    s0 = rsp_seen;
    repeat (8) tick();
    check("midreset_no_rsp", 64'(rsp_seen - s0), 64'd0);
    check("midreset_still_idle", 64'(req_ready), 64'd1);
    rsp_delay = 0;

    // Surviving line still hits after the abort.
    send(1'b0, 8'h40, '0, 32'h4040_4040, 1'b1, 1'b0, 1'b1, 0, lat);
    check("post_reset_hit_latency", 64'(lat), 64'd2);

    check("rd_wr_overlap", 64'(rw_overlap), 64'd0);
    check("rsp_hold_stable", 64'(hold_bad), 64'd0);
    check("mem_req_stable", 64'(mem_unstable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
